// File: rtl/mem_access_sequencer_if.sv
// Pipeline-side and SRAM-side signal bundle for mem_access_sequencer.
// The slave modport is the sequencer's view; master is the pipeline/SRAM environment.
interface mem_access_sequencer_if #(
  parameter int unsigned SRAM_AW = 18
) ();
  logic               memRead;
  logic               memWrite;
  logic [31:0]        address;
  logic [31:0]        writeData;
  logic [31:0]        readData;
  logic               ready;
  logic [SRAM_AW-1:0] sramAddr;
  logic [15:0]        sramDqOut;
  logic [15:0]        sramDqIn;
  logic               sramDqOe;
  logic               sramWeN;

  modport slave (
    input  memRead, memWrite, address, writeData, sramDqIn,
    output readData, ready, sramAddr, sramDqOut, sramDqOe, sramWeN
  );

  modport master (
    output memRead, memWrite, address, writeData, sramDqIn,
    input  readData, ready, sramAddr, sramDqOut, sramDqOe, sramWeN
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Splits 32-bit MEM-stage accesses into two wait-stated 16-bit SRAM cycles, stalling via ready.
// Optional single-entry last-read cache enabled by defining LAST_READ_CACHE_EN.
module mem_access_sequencer #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               op_wr_q, op_wr_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [15:0]        lo_q, lo_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] saddr_q, saddr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               dq_oe_q, dq_oe_d;
  logic               we_n_q, we_n_d;
  logic               ready_s;

  logic               req_s;
  logic               is_wr_s;
  logic [31:0]        offset_s;
  logic [SRAM_AW-2:0] word_s;
  logic               last_s;
  logic               hit_s;
  logic [31:0]        hit_data_s;
  logic               unused_s;

  assign req_s    = bus.memRead | bus.memWrite;
  assign is_wr_s  = bus.memWrite & ~bus.memRead;
  assign offset_s = bus.address - BASE_ADDR;
  assign word_s   = offset_s[SRAM_AW:2];
  assign last_s   = (cnt_q == LAST_CNT);
  assign unused_s = ^{offset_s[31:SRAM_AW+1], offset_s[1:0]};

`ifdef LAST_READ_CACHE_EN
  logic               cvld_q, cvld_d;
  logic [SRAM_AW-2:0] ctag_q, ctag_d;
  logic [31:0]        cdata_q, cdata_d;

  assign hit_s      = req_s & ~is_wr_s & cvld_q & (ctag_q == word_s);
  assign hit_data_s = cdata_q;

  // Cache entry: write-through on a matching store, refill when a read completes
  always_comb begin
    cvld_d  = cvld_q;
    ctag_d  = ctag_q;
    cdata_d = cdata_q;
    if ((state_q == S_IDLE) && req_s && is_wr_s && cvld_q && (ctag_q == word_s)) begin
      cdata_d = bus.writeData;
    end else if ((state_q == S_HI) && last_s && !op_wr_q) begin
      cvld_d  = 1'b1;
      ctag_d  = word_q;
      cdata_d = {bus.sramDqIn, lo_q};
    end else begin
      cvld_d  = cvld_q;
    end
  end

  // Cache entry registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cvld_q  <= 1'b0;
      ctag_q  <= '0;
      cdata_q <= 32'd0;
    end else begin
      cvld_q  <= cvld_d;
      ctag_q  <= ctag_d;
      cdata_q <= cdata_d;
    end
  end
`else
  assign hit_s      = 1'b0;
  assign hit_data_s = 32'd0;
`endif

  // Sequencer next state; SRAM pad outputs are computed for the upcoming state so they flop cleanly
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_wr_d  = op_wr_q;
    word_d   = word_q;
    wdata_d  = wdata_q;
    lo_d     = lo_q;
    rdata_d  = rdata_q;
    saddr_d  = saddr_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = dq_oe_q;
    we_n_d   = we_n_q;
    ready_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!req_s) begin
          ready_s = 1'b1;
        end else if (hit_s) begin
          ready_s = 1'b1;
          rdata_d = hit_data_s;
        end else begin
          op_wr_d  = is_wr_s;
          word_d   = word_s;
          wdata_d  = bus.writeData;
          cnt_d    = 4'd0;
          state_d  = S_LO;
          saddr_d  = {word_s, 1'b0};
          dq_out_d = bus.writeData[15:0];
          dq_oe_d  = is_wr_s;
          we_n_d   = ~is_wr_s;
        end
      end
      S_LO: begin
        if (last_s) begin
          if (!op_wr_q) begin
            lo_d = bus.sramDqIn;
          end else begin
            lo_d = lo_q;
          end
          cnt_d    = 4'd0;
          state_d  = S_HI;
          saddr_d  = {word_q, 1'b1};
          dq_out_d = wdata_q[31:16];
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HI: begin
        if (last_s) begin
          if (!op_wr_q) begin
            rdata_d = {bus.sramDqIn, lo_q};
          end else begin
            rdata_d = rdata_q;
          end
          cnt_d   = 4'd0;
          state_d = S_DONE;
          dq_oe_d = 1'b0;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        ready_s = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        dq_oe_d = 1'b0;
        we_n_d  = 1'b1;
      end
    endcase
  end

  // State, latched request and registered SRAM/pipeline outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      op_wr_q  <= 1'b0;
      word_q   <= '0;
      wdata_q  <= 32'd0;
      lo_q     <= 16'd0;
      rdata_q  <= 32'd0;
      saddr_q  <= '0;
      dq_out_q <= 16'd0;
      dq_oe_q  <= 1'b0;
      we_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_wr_q  <= op_wr_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      lo_q     <= lo_d;
      rdata_q  <= rdata_d;
      saddr_q  <= saddr_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      we_n_q   <= we_n_d;
    end
  end

  assign bus.readData  = rdata_q;
  assign bus.ready     = ready_s;
  assign bus.sramAddr  = saddr_q;
  assign bus.sramDqOut = dq_out_q;
  assign bus.sramDqOe  = dq_oe_q;
  assign bus.sramWeN   = we_n_q;

endmodule
